// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//   Fetch-stage program counter and instruction-memory requester. Keeps the
//   architectural PC and issues one request at a time on a req/gnt/rvalid bus.
//   It applies downstream stalls and branch redirects, and presents pc_out,
//   instr_out and instr_valid to the PC delay stage.
//
// Ports
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   en                     start/continue fetching (0 parks the unit in IDLE)
//   stall                  downstream busy: hold outputs, no new request
//   br_taken, br_target    one-cycle redirect pulse and its target PC
//   imem_req, imem_addr    request valid and address (address = pc)
//   imem_gnt               request accepted this cycle
//   imem_rvalid, imem_rdata  response valid and instruction
//   pc_out, instr_out      PC and instruction of the last accepted fetch
//   instr_valid            pc_out/instr_out valid
//   flush_out              one-cycle pulse after a redirect outside IDLE
//
// Optional build macro
//   PC_FETCH_PERF_EN       adds saturating fetch_cnt / squash_cnt outputs
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     INSTR_W  = 32,
  parameter int unsigned     PC_INC   = 1,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
`ifdef PC_FETCH_PERF_EN
  output logic [15:0]        fetch_cnt,
  output logic [15:0]        squash_cnt,
`endif
  output logic               flush_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic [PC_W-1:0] PC_INC_V = PC_W'(PC_INC);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    pc_out_q, pc_out_d;
  logic [INSTR_W-1:0] instr_out_q, instr_out_d;
  logic               instr_valid_q, instr_valid_d;
  logic               flush_q, flush_d;
  logic               squash_q, squash_d;
  logic               capture_s;
  logic               drop_s;

`ifdef PC_FETCH_PERF_EN
  logic [15:0]        fetch_cnt_q, fetch_cnt_d;
  logic [15:0]        squash_cnt_q, squash_cnt_d;
`endif

  // Request is decoded from registered state, so the address (pc_q) cannot
  // move while a request waits for its grant unless a redirect arrives.
  assign imem_req    = (state_q == ST_ISSUE) && !stall;
  assign imem_addr   = pc_q;
  assign pc_out      = pc_out_q;
  assign instr_out   = instr_out_q;
  assign instr_valid = instr_valid_q;
  assign flush_out   = flush_q;

  // Next-state and datapath decode for the fetch FSM.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_out_d      = pc_out_q;
    instr_out_d   = instr_out_q;
    instr_valid_d = instr_valid_q;
    flush_d       = 1'b0;
    squash_d      = squash_q;
    capture_s     = 1'b0;
    drop_s        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_ISSUE;
        else    state_d = ST_IDLE;
      end
      ST_ISSUE: begin
        if (imem_req && imem_gnt) state_d = ST_WAIT;
        else if (!en)             state_d = ST_IDLE;
        else                      state_d = ST_ISSUE;
      end
      ST_WAIT: begin
        // An outstanding response always completes, regardless of en.
        if (imem_rvalid) begin
          state_d  = ST_ISSUE;
          squash_d = 1'b0;
          if (squash_q || br_taken) drop_s    = 1'b1;
          else                      capture_s = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture_s) begin
      pc_out_d      = pc_q;
      instr_out_d   = imem_rdata;
      instr_valid_d = 1'b1;
      pc_d          = pc_q + PC_INC_V;
    end else if (stall) begin
      instr_valid_d = instr_valid_q;
    end else begin
      instr_valid_d = 1'b0;
    end

    // Redirect wins over stall and the sequential update. A request that is
    // in flight after this cycle must have its response discarded.
    if (br_taken) begin
      pc_d          = br_target;
      instr_valid_d = 1'b0;
      if (state_q != ST_IDLE) flush_d = 1'b1;
      else                    flush_d = 1'b0;
      if (((state_q == ST_ISSUE) && imem_req && imem_gnt) ||
          ((state_q == ST_WAIT) && !imem_rvalid)) begin
        squash_d = 1'b1;
      end else begin
        squash_d = squash_d;
      end
    end else begin
      pc_d = pc_d;
    end
  end

`ifdef PC_FETCH_PERF_EN
  assign fetch_cnt  = fetch_cnt_q;
  assign squash_cnt = squash_cnt_q;

  // Saturating counters of accepted and discarded responses.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (capture_s && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_d = fetch_cnt_q + 16'd1;
    else                                        fetch_cnt_d = fetch_cnt_q;
    if (drop_s && (squash_cnt_q != 16'hFFFF))   squash_cnt_d = squash_cnt_q + 16'd1;
    else                                        squash_cnt_d = squash_cnt_q;
  end
`endif

  // All state registers; reset drops any outstanding transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      pc_out_q      <= '0;
      instr_out_q   <= '0;
      instr_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      squash_q      <= 1'b0;
`ifdef PC_FETCH_PERF_EN
      fetch_cnt_q   <= 16'd0;
      squash_cnt_q  <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_out_q      <= pc_out_d;
      instr_out_q   <= instr_out_d;
      instr_valid_q <= instr_valid_d;
      flush_q       <= flush_d;
      squash_q      <= squash_d;
`ifdef PC_FETCH_PERF_EN
      fetch_cnt_q   <= fetch_cnt_d;
      squash_cnt_q  <= squash_cnt_d;
`endif
    end
  end

endmodule
